wbgpio_irq: RTL and testbench

Parametrised Wishbone GPIO controller for up to 16 bidirectional pins, with per-pin direction control and per-pin, per-edge latched interrupts. It keeps the single-cycle masked set/clear write style for outputs and adds an output-enable register, rising/falling edge-enable registers and a write-1-to-clear pending register. It sits on the 32-bit peripheral Wishbone bus next to the other slow peripherals, with its pads driven through tristate buffers at the top level.

---
 rtl/wbgpio_irq.sv | 129 ++++++++++++
 tb/tb_wbgpio_irq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wbgpio_irq.sv
// Wishbone GPIO controller with per-pin direction control and latched, per-edge
// interrupts. Writes to DATA and DIR use the masked set/clear form; PEND is write-1-to-clear.
module wbgpio_irq #(
  parameter int          NPINS       = 16,
  parameter logic [15:0] DEFAULT_OUT = 16'h0000,
  parameter logic [15:0] DEFAULT_OE  = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [31:0]      o_wb_data,
  input  logic [NPINS-1:0] i_gpio,
  output logic [NPINS-1:0] o_gpio,
  output logic [NPINS-1:0] o_gpio_oe,
  output logic             o_int
);

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DIR   = 2'd1,
    REG_IRQEN = 2'd2,
    REG_PEND  = 2'd3
  } reg_addr_t;

  logic [NPINS-1:0] sync_x, sync_s, sync_p;
  logic [NPINS-1:0] rise_en, fall_en, pend;
  logic [NPINS-1:0] rise, fall, pend_clr;
  logic [NPINS-1:0] wr_mask, wr_val;
  logic [15:0]      s_pad, out_pad, oe_pad, rise_en_pad, fall_en_pad, pend_pad;
  logic [31:0]      rd_mux;
  logic             xfer, wr_en, rd_en;
  reg_addr_t        addr;

  assign o_wb_stall = 1'b0;
  assign xfer  = i_wb_cyc & i_wb_stb;
  assign wr_en = xfer & i_wb_we;
  assign rd_en = xfer & ~i_wb_we;
  assign addr  = reg_addr_t'(i_wb_addr);

  assign wr_mask = i_wb_data[16 +: NPINS];
  assign wr_val  = i_wb_data[0 +: NPINS];

  assign rise = sync_s & ~sync_p;
  assign fall = ~sync_s & sync_p;

  always_comb begin
    s_pad       = '0;
    out_pad     = '0;
    oe_pad      = '0;
    rise_en_pad = '0;
    fall_en_pad = '0;
    pend_pad    = '0;
    pend_clr    = '0;
    s_pad[NPINS-1:0]       = sync_s;
    out_pad[NPINS-1:0]     = o_gpio;
    oe_pad[NPINS-1:0]      = o_gpio_oe;
    rise_en_pad[NPINS-1:0] = rise_en;
    fall_en_pad[NPINS-1:0] = fall_en;
    pend_pad[NPINS-1:0]    = pend;
    if (wr_en && addr == REG_PEND) pend_clr = wr_val;
    unique case (addr)
      REG_DATA:  rd_mux = {s_pad, out_pad};
      REG_DIR:   rd_mux = {16'h0000, oe_pad};
      REG_IRQEN: rd_mux = {fall_en_pad, rise_en_pad};
      REG_PEND:  rd_mux = {16'h0000, pend_pad};
      default:   rd_mux = '0;
    endcase
  end

  // Pad inputs are asynchronous: two flops to synchronise, a third to remember the previous level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_x <= '0;
      sync_s <= '0;
      sync_p <= '0;
    end else begin
      sync_x <= i_gpio;
      sync_s <= sync_x;
      sync_p <= sync_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gpio    <= DEFAULT_OUT[NPINS-1:0];
      o_gpio_oe <= DEFAULT_OE[NPINS-1:0];
      rise_en   <= '0;
      fall_en   <= '0;
    end else if (wr_en) begin
      unique case (addr)
        REG_DATA:  o_gpio    <= (o_gpio & ~wr_mask) | (wr_val & wr_mask);
        REG_DIR:   o_gpio_oe <= (o_gpio_oe & ~wr_mask) | (wr_val & wr_mask);
        REG_IRQEN: begin
          rise_en <= wr_val;
          fall_en <= wr_mask;
        end
        default: ;
      endcase
    end
  end

  // A newly detected enabled edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend  <= '0;
      o_int <= 1'b0;
    end else begin
      pend  <= (pend & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
      o_int <= |pend;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= xfer;
      if (rd_en) o_wb_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_wbgpio_irq.sv
// Directed bench for wbgpio_irq: a vector table for register access plus hand-written
// edge/interrupt, race, reset and narrow-build sequences.
module tb_wbgpio_irq;

  logic        clk;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [15:0] gpio_in;

  logic        ack16, stall16, int16;
  logic [31:0] rdata16;
  logic [15:0] gpio16, oe16;

  logic        ack4, stall4, int4;
  logic [31:0] rdata4;
  logic [3:0]  gpio4, oe4;

  int total = 0;
  int bad   = 0;

  logic        seen_ack;
  logic [31:0] seen_rd;

  wbgpio_irq #(.NPINS(16)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack16), .o_wb_stall(stall16), .o_wb_data(rdata16),
    .i_gpio(gpio_in), .o_gpio(gpio16), .o_gpio_oe(oe16), .o_int(int16)
  );

  wbgpio_irq #(.NPINS(4), .DEFAULT_OUT(16'h0005), .DEFAULT_OE(16'h0000)) dut4 (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack4), .o_wb_stall(stall4), .o_wb_data(rdata4),
    .i_gpio(gpio_in[3:0]), .o_gpio(gpio4), .o_gpio_oe(oe4), .o_int(int4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; ack and read data are sampled 1 ns after the completing edge.
  task automatic apply_stimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    seen_ack = ack16;
    seen_rd  = rdata16;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1; cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; gpio_in = 16'h0000;
    seen_ack = 0; seen_rd = 0;

    vecs[0] = '{1'b1, 2'd0, 32'h0003_0001, 1'b0, 32'h0,         16'h0001, 16'h0000};
    vecs[1] = '{1'b1, 2'd0, 32'h0002_0000, 1'b0, 32'h0,         16'h0001, 16'h0000};
    vecs[2] = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0000_0001, 16'h0001, 16'h0000};
    vecs[3] = '{1'b1, 2'd0, 32'h0001_0000, 1'b0, 32'h0,         16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 2'd1, 32'h00FF_00F0, 1'b0, 32'h0,         16'h0000, 16'h00F0};
    vecs[5] = '{1'b0, 2'd1, 32'h0,         1'b1, 32'h0000_00F0, 16'h0000, 16'h00F0};
    vecs[6] = '{1'b1, 2'd2, 32'h1234_5678, 1'b0, 32'h0,         16'h0000, 16'h00F0};
    vecs[7] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h1234_5678, 16'h0000, 16'h00F0};
    vecs[8] = '{1'b1, 2'd2, 32'h0000_0000, 1'b0, 32'h0,         16'h0000, 16'h00F0};
    vecs[9] = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h0000_0000, 16'h0000, 16'h00F0};

    #2 reset_n = 1'b0;
    #1;
    check_output("rst_out",   {16'h0, gpio16}, 32'h0);
    check_output("rst_oe",    {16'h0, oe16},   32'h0);
    check_output("rst_int",   {31'h0, int16},  32'h0);
    check_output("rst_ack",   {31'h0, ack16},  32'h0);
    check_output("rst_rdata", rdata16,         32'h0);
    check_output("rst_out4",  {28'h0, gpio4},  32'h5);
    wait_cycles(2);
    @(negedge clk) reset_n = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check_output($sformatf("vec%0d_ack", i), {31'h0, seen_ack}, 32'h1);
      check_output($sformatf("vec%0d_out", i), {16'h0, gpio16}, {16'h0, vecs[i].exp_out});
      check_output($sformatf("vec%0d_oe", i),  {16'h0, oe16},   {16'h0, vecs[i].exp_oe});
      if (vecs[i].chk_rd) check_output($sformatf("vec%0d_rd", i), seen_rd, vecs[i].exp_rd);
      #1;
      @(posedge clk); #1;
      check_output($sformatf("vec%0d_ack_drop", i), {31'h0, ack16}, 32'h0);
    end

    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    check_output("stb_nocyc_ack", {31'h0, ack16}, 32'h0);
    check_output("stb_nocyc_out", {16'h0, gpio16}, 32'h0);

    gpio_in = 16'hA5A5;
    wait_cycles(3);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("data_readback", seen_rd, 32'hA5A5_0000);

    gpio_in = 16'h0000;
    wait_cycles(4);
    apply_stimulus(1'b1, 2'd2, 32'h0000_0004);
    @(negedge clk) gpio_in[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("rise_int_early", {31'h0, int16}, 32'h0);
    @(posedge clk); #1;
    check_output("rise_int", {31'h0, int16}, 32'h1);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("rise_pend", seen_rd, 32'h0000_0004);

    apply_stimulus(1'b1, 2'd3, 32'h0000_0004);
    check_output("clr_int_hold", {31'h0, int16}, 32'h1);
    @(posedge clk); #1;
    check_output("clr_int_fall", {31'h0, int16}, 32'h0);

    gpio_in[2] = 1'b0;
    wait_cycles(5);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("rise_no_fall", seen_rd, 32'h0);

    apply_stimulus(1'b1, 2'd2, 32'h0004_0000);
    gpio_in[2] = 1'b1;
    wait_cycles(5);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("fall_no_rise", seen_rd, 32'h0);
    gpio_in[2] = 1'b0;
    wait_cycles(5);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("fall_pend", seen_rd, 32'h0000_0004);
    check_output("fall_int", {31'h0, int16}, 32'h1);

    gpio_in[2] = 1'b1;
    wait_cycles(5);
    @(negedge clk) gpio_in[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    apply_stimulus(1'b1, 2'd3, 32'h0000_0004);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("race_pend", seen_rd, 32'h0000_0004);
    check_output("race_int", {31'h0, int16}, 32'h1);

    apply_stimulus(1'b1, 2'd3, 32'h0000_0004);
    @(posedge clk); #1;
    check_output("clr2_int", {31'h0, int16}, 32'h0);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("clr2_pend", seen_rd, 32'h0);

    apply_stimulus(1'b1, 2'd0, 32'hFFFF_FFFF);
    check_output("n4_out", {28'h0, gpio4}, 32'hF);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("n4_data_rd", rdata4, 32'h0000_000F);
    check_output("n16_data_rd", seen_rd, 32'h0000_FFFF);
    apply_stimulus(1'b1, 2'd2, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 2'd2, 32'h0);
    check_output("n4_irqen_rd", rdata4, 32'h000F_000F);

    gpio_in[0] = 1'b1;
    wait_cycles(4);
    check_output("pre_rst_int", {31'h0, int16}, 32'h1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'hFFFF_FFFF;
    #2 reset_n = 1'b0;
    #1;
    check_output("midrst_out",   {16'h0, gpio16}, 32'h0);
    check_output("midrst_int",   {31'h0, int16},  32'h0);
    check_output("midrst_rdata", rdata16,         32'h0);
    @(posedge clk); #1;
    check_output("midrst_ack",   {31'h0, ack16},  32'h0);
    check_output("midrst_oe",    {16'h0, oe16},   32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    wait_cycles(1);
    check_output("postrst_oe",   {16'h0, oe16},   32'h0);
    check_output("postrst_out4", {28'h0, gpio4},  32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
